// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// Oversampling asynchronous serial receiver feeding the UART command FSM.
// Deframes start, 8 data bits (LSB first), optional parity and a stop bit,
// and delivers {frame_err, parity_err, data[7:0]} with a one-clock strobe.
// Errored characters are still delivered so the consumer can report them.
//
// Build option:
//   UART_RX_MAJORITY_EN - when defined, every bit is the 2-of-3 majority of
//   samples taken at scnt = OVS/2-2, OVS/2-1 and OVS/2, decided at OVS/2.
//   When undefined, a single sample is taken at scnt = OVS/2-1.

module uart_rx_deframer #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVS        = 16,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic       rx_data_en_o,
   output logic [9:0] rx_data_r_o,
   output logic       busy_o
);

   // Tick divider: rounded ratio of clock to oversample rate, never below 1.
   localparam int TICK_RATE = BAUD * OVS;
   localparam int DIV_RAW   = (CLK_FREQ + TICK_RATE / 2) / TICK_RATE;
   localparam int DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   // Sample counter runs 0..OVS-1 within each bit period.
   localparam int SCNT_W = $clog2(OVS);
   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVS - 1);

`ifdef UART_RX_MAJORITY_EN
   localparam logic [SCNT_W-1:0] VOTE0_PT  = SCNT_W'(OVS / 2 - 2);
   localparam logic [SCNT_W-1:0] VOTE1_PT  = SCNT_W'(OVS / 2 - 1);
   localparam logic [SCNT_W-1:0] DECIDE_PT = SCNT_W'(OVS / 2);
`else
   localparam logic [SCNT_W-1:0] DECIDE_PT = SCNT_W'(OVS / 2 - 1);
`endif

   localparam logic PAR_ODD = (PARITY_ODD != 0);
   localparam logic PAR_EN  = (PARITY_EN != 0);

   // Receiver states.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_PAR   = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;
   localparam logic [2:0] ST_BRK   = 3'd5;

   logic              rx_meta_q, rx_meta_d;
   logic              rx_s_q, rx_s_d;
   logic              rx_prev_q, rx_prev_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [SCNT_W-1:0] scnt_q, scnt_d;
   logic [2:0]        state_q, state_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              par_err_q, par_err_d;
   logic [9:0]        word_q, word_d;
   logic              en_q, en_d;

   logic              tick;
   logic              start_edge;
   logic              sample_pt;
   logic              bit_wrap;
   logic              bit_val;

   // Two-flop synchronizer plus one more stage remembering the previous value
   // of the synchronized line, used only for falling-edge detection.
   always_comb begin
      rx_meta_d = rx_i;
      rx_s_d    = rx_meta_q;
      rx_prev_d = rx_s_q;
   end

   // Falling edge seen while idle marks a candidate start bit.
   always_comb begin
      start_edge = (state_q == ST_IDLE) && rx_prev_q && !rx_s_q;
   end

   // Oversample tick generator; realigned on every start edge so the bit
   // centres sit at a fixed offset from the line transition.
   always_comb begin
      tick      = (div_cnt_q == DIV_LAST);
      div_cnt_d = div_cnt_q + DIV_W'(1);
      if (start_edge || tick) begin
         div_cnt_d = '0;
      end
   end

   // Decision and end-of-bit strobes derived from the sample counter.
   always_comb begin
      sample_pt = tick && (scnt_q == DECIDE_PT);
      bit_wrap  = tick && (scnt_q == SCNT_LAST);
   end

`ifdef UART_RX_MAJORITY_EN
   logic vote0_q, vote0_d;
   logic vote1_q, vote1_d;

   // Capture the two early samples; the third is the live synchronized line
   // at the decision tick, and the bit value is their 2-of-3 majority.
   always_comb begin
      vote0_d = vote0_q;
      vote1_d = vote1_q;
      if (tick && (scnt_q == VOTE0_PT)) begin
         vote0_d = rx_s_q;
      end
      if (tick && (scnt_q == VOTE1_PT)) begin
         vote1_d = rx_s_q;
      end
      bit_val = (vote0_q & vote1_q) | (vote0_q & rx_s_q) | (vote1_q & rx_s_q);
   end

   // Vote sample registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vote0_q <= 1'b0;
         vote1_q <= 1'b0;
      end else begin
         vote0_q <= vote0_d;
         vote1_q <= vote1_d;
      end
   end
`else
   // Single mid-bit sample straight from the synchronizer.
   always_comb begin
      bit_val = rx_s_q;
   end
`endif

   // Frame sequencer: walks start, data, parity and stop bits, builds the
   // output word and fires the strobe at the stop-bit decision point.
   always_comb begin
      state_d   = state_q;
      scnt_d    = scnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      par_err_d = par_err_q;
      word_d    = word_q;
      en_d      = 1'b0;

      if (tick && (state_q != ST_IDLE)) begin
         scnt_d = (scnt_q == SCNT_LAST) ? '0 : scnt_q + SCNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d   = ST_START;
               scnt_d    = '0;
               bit_idx_d = '0;
               par_err_d = 1'b0;
            end
         end
         ST_START: begin
            if (sample_pt && bit_val) begin
               state_d = ST_IDLE;
               scnt_d  = '0;
            end else if (bit_wrap) begin
               state_d   = ST_DATA;
               bit_idx_d = '0;
            end
         end
         ST_DATA: begin
            if (sample_pt) begin
               shift_d[bit_idx_q] = bit_val;
            end
            if (bit_wrap) begin
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = '0;
                  state_d   = PAR_EN ? ST_PAR : ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         ST_PAR: begin
            if (sample_pt) begin
               par_err_d = bit_val ^ (^shift_q) ^ PAR_ODD;
            end
            if (bit_wrap) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (sample_pt) begin
               word_d  = {~bit_val, par_err_q, shift_q};
               en_d    = 1'b1;
               scnt_d  = '0;
               state_d = bit_val ? ST_IDLE : ST_BRK;
            end
         end
         ST_BRK: begin
            if (rx_s_q) begin
               state_d = ST_IDLE;
               scnt_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            scnt_d  = '0;
         end
      endcase
   end

   // State registers; a reset mid-frame drops the frame without a strobe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
         div_cnt_q <= '0;
         scnt_q    <= '0;
         state_q   <= ST_IDLE;
         bit_idx_q <= '0;
         shift_q   <= '0;
         par_err_q <= 1'b0;
         word_q    <= '0;
         en_q      <= 1'b0;
      end else begin
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
         rx_prev_q <= rx_prev_d;
         div_cnt_q <= div_cnt_d;
         scnt_q    <= scnt_d;
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         par_err_q <= par_err_d;
         word_q    <= word_d;
         en_q      <= en_d;
      end
   end

   assign rx_data_en_o = en_q;
   assign rx_data_r_o  = word_q;
   assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer
// Directed bench for uart_rx_deframer at 16 clocks per bit, even parity.
// Frames are driven bit by bit; a negedge monitor logs every strobe with its
// cycle number so counts, words and spacing can be compared afterwards.

module tb_uart_rx_deframer;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       rx_i;
   logic       rx_data_en_o;
   logic [9:0] rx_data_r_o;
   logic       busy_o;

   int tests_run    = 0;
   int tests_failed = 0;
   int cycle        = 0;
   int start_cycle  = 0;

`ifdef UART_RX_MAJORITY_EN
   localparam int EXP_LAT = 2 + 10 * 16 + 8 + 1;
`else
   localparam int EXP_LAT = 2 + 10 * 16 + 8;
`endif

   logic [9:0] word_log[$];
   int         cyc_log[$];

   uart_rx_deframer #(
      .CLK_FREQ  (1_843_200),
      .BAUD      (115200),
      .OVS       (16),
      .PARITY_EN (1),
      .PARITY_ODD(0)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rx_i        (rx_i),
      .rx_data_en_o(rx_data_en_o),
      .rx_data_r_o (rx_data_r_o),
      .busy_o      (busy_o)
   );

   // 10 ns clock.
   always #5 clk_i = ~clk_i;

   // Cycle counter for latency and spacing measurements.
   always @(posedge clk_i) cycle <= cycle + 1;

   // Strobe monitor, sampled away from the active edge.
   always @(negedge clk_i) begin
      if (rx_data_en_o) begin
         word_log.push_back(rx_data_r_o);
         cyc_log.push_back(cycle);
      end
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [9:0] loggedWord(input int idx);
      if (idx < word_log.size()) return word_log[idx];
      return 10'bx;
   endfunction

   function automatic int loggedCycle(input int idx);
      if (idx < cyc_log.size()) return cyc_log[idx];
      return -100000;
   endfunction

   // Drive one bit for 16 clocks; optional one-clock inversion near its centre.
   task automatic driveBit(input logic b, input bit glitch);
      for (int c = 0; c < 16; c++) begin
         rx_i = (glitch && c == 8) ? ~b : b;
         @(negedge clk_i);
      end
   endtask

   // Drive a complete frame: start, data LSB first, parity, stop.
   task automatic applyStimulus(input logic [7:0] data, input logic par_bit,
                                input logic stop_bit, input bit glitch);
      start_cycle = cycle;
      driveBit(1'b0, glitch);
      for (int i = 0; i < 8; i++) driveBit(data[i], glitch);
      driveBit(par_bit, glitch);
      driveBit(stop_bit, glitch);
   endtask

   task automatic idleLine(input int n);
      rx_i = 1'b1;
      repeat (n) @(negedge clk_i);
   endtask

   int n0;
   int lat;
   int gap;

   initial begin
      rx_i  = 1'b1;
      rst_i = 1'b1;
      repeat (4) @(negedge clk_i);
      checkOutput("reset_en",   rx_data_en_o, 0);
      checkOutput("reset_word", rx_data_r_o,  0);
      checkOutput("reset_busy", busy_o,       0);
      rst_i = 1'b0;
      idleLine(20);

      // Good frame 0x3A, even parity bit 0.
      n0 = word_log.size();
      applyStimulus(8'h3A, 1'b0, 1'b1, 1'b0);
      idleLine(20);
      checkOutput("good_count", word_log.size() - n0, 1);
      checkOutput("good_word",  loggedWord(n0), 10'h03A);
      checkOutput("good_busy",  busy_o, 0);
      lat = loggedCycle(n0) - start_cycle;
      checkOutput("good_latency", (lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1) ? EXP_LAT : lat,
                  EXP_LAT);

      // Wrong parity bit on 0x55.
      n0 = word_log.size();
      applyStimulus(8'h55, 1'b1, 1'b1, 1'b0);
      idleLine(20);
      checkOutput("parerr_count", word_log.size() - n0, 1);
      checkOutput("parerr_word",  loggedWord(n0), 10'h155);

      // Framing error followed by a 40-bit break, then recovery.
      n0 = word_log.size();
      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) driveBit(1'b0, 1'b0);
      checkOutput("brk_busy_low_line", busy_o, 1);
      checkOutput("brk_count",         word_log.size() - n0, 1);
      checkOutput("brk_word",          loggedWord(n0), 10'h2A5);
      idleLine(6);
      checkOutput("brk_busy_released", busy_o, 0);
      idleLine(10);
      applyStimulus(8'h0D, 1'b1, 1'b1, 1'b0);
      idleLine(20);
      checkOutput("brk_recover_count", word_log.size() - n0, 2);
      checkOutput("brk_recover_word",  loggedWord(n0 + 1), 10'h00D);

      // Four-clock low glitch while idle is rejected as a false start.
      n0 = word_log.size();
      rx_i = 1'b0;
      repeat (4) @(negedge clk_i);
      rx_i = 1'b1;
      checkOutput("glitch_busy_seen", busy_o, 1);
      repeat (8) @(negedge clk_i);
      checkOutput("glitch_busy_clear", busy_o, 0);
      idleLine(20);
      checkOutput("glitch_no_strobe", word_log.size() - n0, 0);
      applyStimulus(8'h30, 1'b0, 1'b1, 1'b0);
      idleLine(20);
      checkOutput("glitch_next_word", loggedWord(n0), 10'h030);

      // Back-to-back frames with no idle gap.
      n0 = word_log.size();
      applyStimulus(8'h0D, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'h0A, 1'b0, 1'b1, 1'b0);
      idleLine(20);
      checkOutput("b2b_count",  word_log.size() - n0, 2);
      checkOutput("b2b_word0",  loggedWord(n0),     10'h00D);
      checkOutput("b2b_word1",  loggedWord(n0 + 1), 10'h00A);
      gap = loggedCycle(n0 + 1) - loggedCycle(n0);
      checkOutput("b2b_spacing", (gap >= 175 && gap <= 177) ? 176 : gap, 176);

      // Reset pulse during data bit 3 of 0x3A abandons the frame.
      n0 = word_log.size();
      driveBit(1'b0, 1'b0);
      driveBit(1'b0, 1'b0);
      driveBit(1'b1, 1'b0);
      driveBit(1'b0, 1'b0);
      rx_i = 1'b1;
      repeat (8) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      checkOutput("midrst_en",   rx_data_en_o, 0);
      checkOutput("midrst_word", rx_data_r_o,  0);
      checkOutput("midrst_busy", busy_o,       0);
      idleLine(200);
      checkOutput("midrst_no_strobe", word_log.size() - n0, 0);
      applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0);
      idleLine(20);
      checkOutput("midrst_next_count", word_log.size() - n0, 1);
      checkOutput("midrst_next_word",  loggedWord(n0), 10'h0FF);

`ifdef UART_RX_MAJORITY_EN
      // One-clock glitch at every bit centre is outvoted.
      n0 = word_log.size();
      applyStimulus(8'hFF, 1'b0, 1'b1, 1'b1);
      idleLine(20);
      applyStimulus(8'h3A, 1'b0, 1'b1, 1'b1);
      idleLine(20);
      checkOutput("vote_count", word_log.size() - n0, 2);
      checkOutput("vote_word0", loggedWord(n0),     10'h0FF);
      checkOutput("vote_word1", loggedWord(n0 + 1), 10'h03A);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
